// File: rtl/edge_detect_multi_if.sv
// Channel bundle between the raw pad-side inputs and the control/status register block.
// The source of the raw inputs uses master; the edge detector uses slave.
interface edge_detect_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   sig;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   r_edge;
  logic [N_CH-1:0]   f_edge;
  logic [N_CH-1:0]   evt;
  logic [N_CH-1:0]   ovf;
  logic              evt_any;

  modport master (
    output sig, mode, clr,
    input  level, r_edge, f_edge, evt, ovf, evt_any
  );

  modport slave (
    input  sig, mode, clr,
    output level, r_edge, f_edge, evt, ovf, evt_any
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronise / glitch-filter / edge-detect block for asynchronous inputs.
// Mode-qualified edges latch into sticky write-1-to-clear event flags with overflow tracking.
module edge_detect_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic               clk,
  input  logic               nrst,
  edge_detect_multi_if.slave bus
);

  localparam int            CW      = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] r_edge_q, r_edge_d;
  logic [N_CH-1:0] f_edge_q, f_edge_d;
  logic [N_CH-1:0] evt_q, evt_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] qual;

  always_comb begin
    sync_d   = sync_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    r_edge_d = '0;
    f_edge_d = '0;
    evt_d    = evt_q;
    ovf_d    = ovf_q;
    s        = '0;
    qual     = '0;

    for (int i = 0; i < N_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], bus.sig[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];

      // Any agreeing sample restarts the count, so short glitches never accumulate.
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end

      r_edge_d[i] = level_d[i] & ~level_q[i];
      f_edge_d[i] = ~level_d[i] & level_q[i];
      qual[i]     = (bus.mode[2*i] & r_edge_d[i]) | (bus.mode[2*i+1] & f_edge_d[i]);

      // A new event beats a simultaneous clear; the clear consumes the old one, so no overflow.
      if (qual[i]) begin
        evt_d[i] = 1'b1;
        if (evt_q[i] && !bus.clr[i]) begin
          ovf_d[i] = 1'b1;
        end
      end else if (bus.clr[i]) begin
        evt_d[i] = 1'b0;
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      r_edge_q <= '0;
      f_edge_q <= '0;
      evt_q    <= '0;
      ovf_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      r_edge_q <= r_edge_d;
      f_edge_q <= f_edge_d;
      evt_q    <= evt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.level   = level_q;
  assign bus.r_edge  = r_edge_q;
  assign bus.f_edge  = f_edge_q;
  assign bus.evt     = evt_q;
  assign bus.ovf     = ovf_q;
  assign bus.evt_any = |evt_q;

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-signal rising-edge detector, for use on asynchronous UART-side inputs such as RX idle/break detection, CTS, and external strobes.
- Per channel, it:
  - synchronises the raw input;
  - glitch-filters it with a stability counter;
  - produces filtered level, rising-edge and falling-edge pulses;
  - latches mode-qualified events into sticky, write-1-to-clear flags with overflow detection.
- Sits between the pads and the control/status register block.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- FILT_CNT, 4, consecutive synchronised samples that must disagree with the current filtered level before it changes (>=1; 1 = no filtering)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- sig  in  N_CH  raw asynchronous inputs, one per channel
- mode  in  2*N_CH  per-channel event mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  in  N_CH  per-channel write-1-to-clear strobe for evt/ovf
- level  out  N_CH  filtered, synchronised level
- r_edge  out  N_CH  one-cycle pulse on filtered 0->1
- f_edge  out  N_CH  one-cycle pulse on filtered 1->0
- evt  out  N_CH  sticky qualified-event flag
- ovf  out  N_CH  sticky overflow flag
- evt_any  out  1  OR of evt

Behaviour:
- Reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on nrst.
  - On reset, all flops clear to 0: sync chains, filter counters, level, r_edge, f_edge, evt, ovf. evt_any is therefore 0.
  - Reset assertion mid-filter discards partial counts. After release, the first edge cannot fire until the full sync + filter latency has elapsed.
- Synchroniser:
  - SYNC_STAGES-deep flop chain per channel; s = last stage.
  - No logic between stages.
- Filter (per channel):
  - Counter width is clog2(FILT_CNT), minimum 1.
  - Each cycle, if s == level: cnt <= 0.
  - Else if cnt == FILT_CNT-1: level <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any sample where s returns to level resets cnt, so glitches shorter than FILT_CNT cycles at s are fully rejected.
- Edge pulses:
  - r_edge and f_edge are registered and assert in the same cycle that level changes.
  - Each is high for exactly one cycle.
  - The edge pulses are independent of mode.
- Latency:
  - The level change and its edge pulse become visible after the (SYNC_STAGES+FILT_CNT)-th rising clk edge, counting the first edge that samples the new sig value.
  - Defaults: the 6th edge.
  - Same latency for both polarities.
- Qualification:
  - q = (mode[2i] & r_edge_next) | (mode[2i+1] & f_edge_next), where *_next are the values being registered this cycle.
  - evt[i] and ovf[i] therefore update on the same edge as r_edge/f_edge.
- Sticky flags:
  - If q: evt <= 1. If evt is already 1 and clr[i] is not asserted this cycle, also ovf <= 1.
  - Else if clr[i]: evt <= 0, ovf <= 0.
  - Simultaneous q and clr: set wins. evt stays 1 and ovf is not set, because the old event is being consumed.
  - clr with no q clears both flags in the next cycle.
- Mode:
  - Sampled each cycle with no latching.
  - A mode change affects only edges that occur after it.
  - Mode 00 still tracks level and edge pulses but never sets evt/ovf.
- evt_any:
  - Combinational OR of the registered evt.
- Wrap/saturation:
  - The filter counter never exceeds FILT_CNT-1.
  - No wrap is possible.

Test Plan:
- Reset state: assert nrst low mid-run with sig=all 1s -> all outputs 0 immediately (async). Release, hold sig ch0=1 -> level[0] and r_edge[0] rise on the 6th clk edge after the first sampling edge; r_edge[0] is one cycle wide.
- Glitch rejection (defaults): 3-cycle-high pulse on sig[1] -> no level/r_edge/f_edge/evt change. A 4-cycle pulse -> r_edge[1] pulse, then f_edge[1] pulse exactly 4 cycles later. FILT_CNT=1 build: a 1-cycle pulse passes.
- Mode matrix, ch2, full 0->1->0 cycle per mode: mode 01 -> evt set on rise only; 10 -> on fall only; 11 -> on both (second sets ovf); 00 -> evt stays 0 while level/edges still toggle.
- Clear and overflow: mode 01, two rises without clr -> evt=1, ovf=1. clr[3] pulse -> both 0 next cycle, evt_any=0. Rise coincident with clr -> evt=1, ovf=0.
- Multi-channel independence: simultaneous staggered edges on all N_CH channels with mixed modes and clrs -> per-channel flags correct, no cross-talk. evt_any tracks the OR.
- Reset mid-filter: sig[0] rises, nrst pulsed low after 3 filter samples -> no edge. After release, full 6-edge latency is required again.
